hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Replaces the single-cycle `*`, `/` and `%` of the ALU's MULT/MULTU/DIV/DIVU path with an iterative 32-step engine.
- Sits beside the ALU in the execute stage. The decode/execute controller issues ops through a start/busy handshake.
- Produces a stall for MFHI/MFLO while a result is still pending.

---
 rtl/hilo_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/hilo_muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared constants, state type and helpers for the HI/LO
//                multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    localparam int WIDTH = 32;

    // Funct codes recognised by the unit
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MTLO  = 6'd19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    // Absolute value for signed ops, identity for unsigned ops.
    // -2^31 maps to 32'h8000_0000, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of the multiply/divide engine.
//                Multiply: radix-2 shift-add on the {acc, q} pair.
//                Divide  : restoring subtract, quotient bit enters q LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_sum;    // accumulator plus optional multiplicand, with carry
    logic [WIDTH:0]   w_shift;  // 33-bit partial remainder after shifting in next dividend bit
    logic [WIDTH-1:0] w_sub;    // partial remainder minus divisor (valid only when no borrow)
    logic             w_ge;     // partial remainder >= divisor

    // Select the shift-add or the restoring-subtract iteration
    always_comb begin
        w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
        w_shift = {i_acc, i_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_b});
        // When w_ge holds the difference is below the divisor, so it fits in WIDTH bits
        w_sub   = w_shift[WIDTH-1:0] - i_b;
        if (i_is_div) begin
            o_acc = w_ge ? w_sub : w_shift[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_ge};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit
//  Description : Iterative 32-step multiply/divide engine owning the
//                architectural HI/LO registers, with start/busy handshake
//                and MFHI/MFLO stall generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import hilo_pkg::*;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;      // product high half / partial remainder
    logic [WIDTH-1:0] r_q;        // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] r_b;        // multiplicand / divisor magnitude
    logic             r_is_div;
    logic             r_neg_lo;   // negate product (multiply) or quotient (divide)
    logic             r_neg_hi;   // negate remainder (divide only)
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_legal;
    logic             w_is_div_op;
    logic             w_is_signed;
    logic             w_div_zero;
    logic             w_sign1;
    logic             w_sign2;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    // Decode the requested funct code
    always_comb begin
        w_legal     = (op == FN_MULT) || (op == FN_MULTU) || (op == FN_DIV) ||
                      (op == FN_DIVU) || (op == FN_MTHI)  || (op == FN_MTLO);
        w_is_div_op = (op == FN_DIV)  || (op == FN_DIVU);
        w_is_signed = (op == FN_MULT) || (op == FN_DIV);
        w_div_zero  = w_is_div_op && (op2 == {WIDTH{1'b0}});
        w_sign1     = w_is_signed && op1[WIDTH-1];
        w_sign2     = w_is_signed && op2[WIDTH-1];
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_b      (r_b),
        .o_acc    (w_step_acc),
        .o_q      (w_step_q)
    );

    // Apply the latched sign corrections to the raw magnitude result
    always_comb begin
        w_prod = r_neg_lo ? -{r_acc, r_q} : {r_acc, r_q};
        if (r_is_div) begin
            w_fix_hi = r_neg_hi ? -r_acc : r_acc;
            w_fix_lo = r_neg_lo ? -r_q   : r_q;
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_legal) begin
                        if (op == FN_MTHI) begin
                            r_hi <= op1;
                        end else if (op == FN_MTLO) begin
                            r_lo <= op1;
                        end else begin
                            r_is_div <= w_is_div_op;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            if (w_div_zero) begin
                                // Forced result: quotient all ones, remainder = dividend
                                r_acc    <= op1;
                                r_q      <= '1;
                                r_b      <= '0;
                                r_neg_lo <= 1'b0;
                                r_neg_hi <= 1'b0;
                                r_state  <= FIXUP;
                            end else begin
                                r_acc    <= '0;
                                r_q      <= magnitude(op1, w_is_signed);
                                r_b      <= magnitude(op2, w_is_signed);
                                r_neg_lo <= w_sign1 ^ w_sign2;
                                r_neg_hi <= w_is_div_op && w_sign1;
                                r_state  <= CALC;
                            end
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_step_acc;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = rd_req & r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_unit
//  Description : Self-checking bench for hilo_muldiv_unit: arithmetic model
//                compared every cycle plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;

    import hilo_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [5:0]  op      = 6'd0;
    logic [31:0] op1     = '0;
    logic [31:0] op2     = '0;
    logic        rd_req  = 1'b0;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .op1     (op1),
        .op2     (op2),
        .rd_req  (rd_req),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an arithmetic op, straight from the op definitions
    task automatic model_result(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        logic signed [63:0] sp;
        logic [63:0]        up;
        lat = 33;
        rhi = '0;
        rlo = '0;
        case (o)
            FN_MULT: begin
                sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                rhi = sp[63:32];
                rlo = sp[31:0];
            end
            FN_MULTU: begin
                up  = {32'd0, a} * {32'd0, b};
                rhi = up[63:32];
                rlo = up[31:0];
            end
            FN_DIV: begin
                if (b == 32'd0) begin
                    rlo = 32'hFFFF_FFFF; rhi = a; lat = 1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rlo = 32'h8000_0000; rhi = 32'd0;
                end else begin
                    rlo = $signed(a) / $signed(b);
                    rhi = $signed(a) % $signed(b);
                end
            end
            default: begin // FN_DIVU
                if (b == 32'd0) begin
                    rlo = 32'hFFFF_FFFF; rhi = a; lat = 1;
                end else begin
                    rlo = a / b;
                    rhi = a % b;
                end
            end
        endcase
    endtask

    // Behavioural model: pending-result countdown, updated on the DUT's clock and reset
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_rem = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_busy = 1'b0;
                end
            end else if (start) begin
                if (op == FN_MTHI) m_hi = op1;
                else if (op == FN_MTLO) m_lo = op1;
                else if (op == FN_MULT || op == FN_MULTU || op == FN_DIV || op == FN_DIVU) begin
                    model_result(op, op1, op2, p_hi, p_lo, m_rem);
                    m_busy = 1'b1;
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("cyc_busy",  {31'd0, busy},  {31'd0, m_busy});
        chk("cyc_done",  {31'd0, done},  {31'd0, m_done});
        chk("cyc_stall", {31'd0, stall}, {31'd0, rd_req & m_busy});
        chk("cyc_hi",    hi, m_hi);
        chk("cyc_lo",    lo, m_lo);
    end

    // Present a request and hold it until the accept edge; returns just after that edge
    task automatic start_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        start = 1'b1; op = o; op1 = a; op2 = b;
        while (busy && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=busy required=idle");
        end
        @(posedge clk); #2;
        start = 1'b0; op = 6'd0; op1 = $urandom; op2 = $urandom;
    endtask

    // Count edges from accept to done and cycles with busy high, bounded
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 50) begin
            @(posedge clk); #2;
            lat++;
            if (!done && busy) bcnt++;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat);
        int lat, bcnt;
        start_op(o, a, b);
        wait_done(lat, bcnt);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_busycyc"}, bcnt, elat);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    initial begin
        int lat, bcnt;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #2;

        run_op("mult_neg",   FN_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
        run_op("multu_max",  FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("div_neg",    FN_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu",       FN_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         33);
        run_op("div_ovf",    FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33);
        run_op("mult_mixed", FN_MULT,  32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("divu_zero",  FN_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 1);

        // MULT in flight: competing MTHI is held off, MFHI/MFLO stalls
        start_op(FN_MULT, 32'd5, 32'd6);
        start = 1'b1; op = FN_MTHI; op1 = 32'hDEAD_BEEF; rd_req = 1'b1;
        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("busy_stall", {31'd0, stall}, 32'd1);
        chk("busy_hi_hold", hi, 32'h1234_5678);
        start = 1'b0; op = 6'd0; rd_req = 1'b0;
        wait_done(lat, bcnt);
        chk("mult_small_latency", lat, 28);
        chk("mult_small_hi", hi, 32'd0);
        chk("mult_small_lo", lo, 32'd30);
        start_op(FN_MTLO, 32'd5, 32'd0);
        chk("mtlo_lo", lo, 32'd5);
        chk("mtlo_nodone", {31'd0, done}, 32'd0);
        start_op(FN_MTHI, 32'hCAFE_0001, 32'd0);
        chk("mthi_hi", hi, 32'hCAFE_0001);

        // Illegal code with start held: nothing happens
        start = 1'b1; op = 6'd0; op1 = 32'h1111_1111;
        repeat (3) begin
            @(posedge clk); #2;
        end
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;

        // Asynchronous reset part-way through a divide
        start_op(FN_DIV, 32'd100, 32'd7);
        repeat (10) begin
            @(posedge clk); #2;
        end
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        run_op("multu_post", FN_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33);

        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
